// File: rtl/fifo_burst_reader.sv
// Burst reader that pops a byte FIFO in bounded bursts and forwards the bytes
// through a two-entry skid buffer to a valid/ready downstream port.
module fifo_burst_reader #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        buf_empty,
    input  logic        fifo_threshold,
    input  logic [7:0]  buf_out,
    output logic        rd_en,
    input  logic        flush,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] rd_count
);

    localparam logic [6:0] BurstLenC = 7'(BURST_LEN);
    localparam logic [7:0] TimeoutC  = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    state_e      state_q;
    logic [7:0]  idle_cnt_q;
    logic [6:0]  burst_cnt_q;
    logic        busy_q;
    logic        in_flight_q;
    logic [15:0] rd_count_q;

    logic [7:0]  head_q, head_d;
    logic [7:0]  tail_q, tail_d;
    logic        head_vld_q, head_vld_d;
    logic        tail_vld_q, tail_vld_d;

    logic        pop;
    logic        cap;
    logic [1:0]  occ;
    logic [1:0]  slots_used;
    logic        start;
    logic        burst_done;
    logic        drained;

    assign pop = head_vld_q & m_ready;
    assign cap = in_flight_q;
    assign occ = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

    // Slots still committed after this cycle's pop; lets a read issue in the
    // same cycle a byte leaves, which is what sustains one byte per cycle.
    assign slots_used = occ + {1'b0, in_flight_q} - {1'b0, pop};

    assign rd_en = (state_q == StBurst) & ~buf_empty & (burst_cnt_q < BurstLenC)
                 & (slots_used < 2'd2);

    assign start      = ~buf_empty & (fifo_threshold | flush | (idle_cnt_q == TimeoutC));
    assign burst_done = (burst_cnt_q == BurstLenC) | (buf_empty & ~rd_en);
    assign drained    = ~head_vld_q & ~tail_vld_q & ~in_flight_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idle_cnt_q  <= 8'd0;
            burst_cnt_q <= 7'd0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StBurst;
                        burst_cnt_q <= 7'd0;
                        idle_cnt_q  <= 8'd0;
                        busy_q      <= 1'b1;
                    end else if (buf_empty) begin
                        idle_cnt_q <= 8'd0;
                    end else if (idle_cnt_q != TimeoutC) begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
                StBurst: begin
                    if (rd_en) begin
                        burst_cnt_q <= burst_cnt_q + 7'd1;
                    end
                    if (burst_done) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        if (flush && !buf_empty) begin
                            state_q     <= StBurst;
                            burst_cnt_q <= 7'd0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= 1'b0;
            rd_count_q  <= 16'd0;
        end else begin
            in_flight_q <= rd_en;
            rd_count_q  <= rd_count_q + 16'(rd_en);
        end
    end

    // Head always holds the oldest byte; a pop shifts the tail forward.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        case ({cap, pop})
            2'b10: begin
                if (!head_vld_q) begin
                    head_d     = buf_out;
                    head_vld_d = 1'b1;
                end else begin
                    tail_d     = buf_out;
                    tail_vld_d = 1'b1;
                end
            end
            2'b01: begin
                if (tail_vld_q) begin
                    head_d     = tail_q;
                    tail_vld_d = 1'b0;
                end else begin
                    head_vld_d = 1'b0;
                end
            end
            2'b11: begin
                if (tail_vld_q) begin
                    head_d = tail_q;
                    tail_d = buf_out;
                end else begin
                    head_d = buf_out;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= 8'd0;
            tail_q     <= 8'd0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

    assign m_data   = head_q;
    assign m_valid  = head_vld_q;
    assign busy     = busy_q;
    assign rd_count = rd_count_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && buf_empty));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(cap && !pop && tail_vld_q));

endmodule
